// File: rtl/tb_run_ctrl.sv
// tb_run_ctrl: run controller for a CPU under test. It holds the CPU in reset,
// lets it run, counts cycles and retired writebacks, folds writebacks into a
// signature, and ends the run on a halt write or on timeout.
// Optional feature macro: TB_RUN_CTRL_SIG_EN (signature register and exp_sig
// compare). With the macro undefined, sig stays 0 and a halt always passes.
//
// state  | meaning
// IDLE   | waiting for start, CPU held in reset
// RST    | CPU reset held for RST_CYCLES more cycles
// RUN    | CPU running, writebacks counted, timeout armed
// DONE   | verdict held until the next start

module tb_run_ctrl #(
  parameter int                DATA_W     = 32,
  parameter int                ADDR_W     = 5,
  parameter int                CNT_W      = 16,
  parameter int                RST_CYCLES = 5,
  parameter int                TIMEOUT    = 1000,
  parameter logic [ADDR_W-1:0] HALT_REG   = 2,
  parameter logic [DATA_W-1:0] HALT_VAL   = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              wb_we,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic [DATA_W-1:0] exp_sig,
  output logic              cpu_rst,
  output logic              running,
  output logic              done,
  output logic              pass,
  output logic [CNT_W-1:0]  cycles,
  output logic [CNT_W-1:0]  retired,
  output logic [DATA_W-1:0] sig
);

  typedef enum logic [1:0] {S_IDLE, S_RST, S_RUN, S_DONE} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [7:0]          r_rst_cnt;
  logic                r_cpu_rst;
  logic                r_running;
  logic                r_done;
  logic                r_pass;
  logic [CNT_W-1:0]    r_cycles;
  logic [CNT_W-1:0]    r_retired;
  logic [DATA_W-1:0]   r_sig;

  logic                w_in_run;
  logic                w_wb_cnt;
  logic                w_halt;
  logic                w_timeout;
  logic                w_clear;
  logic [DATA_W-1:0]   w_sig_upd;
  logic                w_pass_halt;

  assign w_in_run  = (r_state == S_RUN);
  assign w_wb_cnt  = w_in_run && wb_we && (wb_addr != '0);
  assign w_halt    = w_wb_cnt && (wb_addr == HALT_REG) && (wb_data == HALT_VAL);
  // Halt takes precedence, so timeout only counts when no halt arrives.
  assign w_timeout = w_in_run && !w_halt && (r_cycles == CNT_W'(TIMEOUT - 1));
  assign w_clear   = start && ((r_state == S_IDLE) || (r_state == S_DONE));

`ifdef TB_RUN_CTRL_SIG_EN
  // Signature folds the rotated previous value with the write data and index.
  assign w_sig_upd   = {r_sig[DATA_W-2:0], r_sig[DATA_W-1]} ^ wb_data ^ DATA_W'(wb_addr);
  assign w_pass_halt = (w_sig_upd == exp_sig);
`else
  logic w_unused_exp_sig;
  assign w_unused_exp_sig = ^exp_sig;
  assign w_sig_upd        = '0;
  assign w_pass_halt      = 1'b1;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RST;
      S_RST:   if (r_rst_cnt == 8'd0) w_state_nxt = S_RUN;
      S_RUN:   if (w_halt || w_timeout) w_state_nxt = S_DONE;
      S_DONE:  if (start) w_state_nxt = S_RST;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // CPU reset hold timer: loaded on entry to RST, counts down to terminal zero.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_rst_cnt <= 8'd0;
    end else if (w_clear) begin
      r_rst_cnt <= 8'(RST_CYCLES);
    end else if ((r_state == S_RST) && (r_rst_cnt != 8'd0)) begin
      r_rst_cnt <= r_rst_cnt - 8'd1;
    end
  end

  // Registered status outputs, run counters, signature and verdict.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cpu_rst <= 1'b1;
      r_running <= 1'b0;
      r_done    <= 1'b0;
      r_pass    <= 1'b0;
      r_cycles  <= '0;
      r_retired <= '0;
      r_sig     <= '0;
    end else begin
      r_cpu_rst <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_RST);
      r_running <= (w_state_nxt == S_RUN);
      r_done    <= (w_state_nxt == S_DONE);
      if (w_clear) begin
        r_pass    <= 1'b0;
        r_cycles  <= '0;
        r_retired <= '0;
        r_sig     <= '0;
      end else if (w_in_run) begin
        // cycles freezes on the cycle that ends the run.
        if (!w_halt && !w_timeout && (r_cycles != '1)) r_cycles <= r_cycles + 1'b1;
        if (w_wb_cnt) begin
          if (r_retired != '1) r_retired <= r_retired + 1'b1;
          r_sig <= w_sig_upd;
        end
        if (w_halt)         r_pass <= w_pass_halt;
        else if (w_timeout) r_pass <= 1'b0;
      end
    end
  end

  assign cpu_rst = r_cpu_rst;
  assign running = r_running;
  assign done    = r_done;
  assign pass    = r_pass;
  assign cycles  = r_cycles;
  assign retired = r_retired;
  assign sig     = r_sig;

endmodule

// File: tb/tb_tb_run_ctrl.sv
// Directed bench for tb_run_ctrl: a per-cycle vector table plus hand-written
// sequences for halt-at-timeout, failing signature and reset mid-run.
// Built with TIMEOUT=8 so timeout paths stay short.

module tb_tb_run_ctrl;

`ifdef TB_RUN_CTRL_SIG_EN
  localparam bit SIG_EN = 1'b1;
`else
  localparam bit SIG_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, start, wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data, exp_sig;
  logic        cpu_rst, running, done, pass;
  logic [15:0] cycles, retired;
  logic [31:0] sig;

  int n_chk = 0;
  int n_err = 0;

  tb_run_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .start(start), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data(wb_data), .exp_sig(exp_sig), .cpu_rst(cpu_rst), .running(running),
    .done(done), .pass(pass), .cycles(cycles), .retired(retired), .sig(sig)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rst, start, we;
    logic [4:0]  addr;
    logic [31:0] data, esig;
    logic        cr, run, dn, pe, pd, cc;
    logic [15:0] cyc, ret;
    logic [31:0] sg;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic r, s, we, input logic [4:0] a,
                     input logic [31:0] d, es,
                     input logic cr, run, dn, pe, pd, cc,
                     input logic [15:0] cy, rt, input logic [31:0] sg);
    vec_t v;
    v.rst = r; v.start = s; v.we = we; v.addr = a; v.data = d; v.esig = es;
    v.cr = cr; v.run = run; v.dn = dn; v.pe = pe; v.pd = pd; v.cc = cc;
    v.cyc = cy; v.ret = rt; v.sg = sg;
    tbl.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got %0h expected %0h", nm, got, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample outputs 1 time unit after the edge.
  task automatic step(input logic r, s, we, input logic [4:0] a, input logic [31:0] d);
    rst = r; start = s; wb_we = we; wb_addr = a; wb_data = d;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] xsig(input logic [31:0] v);
    return SIG_EN ? v : 32'h0;
  endfunction

  // From IDLE or DONE: start pulse, five RST cycles, then first RUN cycle.
  task automatic run_up(input string nm);
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 0, 0);
    chk({nm, "_cpu_rst_hold"}, {31'b0, cpu_rst}, 32'd1);
    step(0, 0, 0, 0, 0);
    chk({nm, "_running"}, {31'b0, running}, 32'd1);
    chk({nm, "_cycles0"}, {16'b0, cycles}, 32'd0);
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; wb_we = 1'b0; wb_addr = '0; wb_data = '0; exp_sig = '0;

    //   rst s we addr data          esig          cr r d pe pd cc cyc ret sig
    add(1, 0, 0, 0, 32'h0,        32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    add(0, 1, 0, 0, 32'h0,        32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    add(0, 0, 1, 1, 32'h10,       32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    add(0, 1, 0, 0, 32'h0,        32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    for (int i = 0; i < 3; i++)
      add(0, 0, 0, 0, 32'h0,      32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        32'hFFFFFFDF, 0,1,0,0,0,1, 0,0, 32'h0);
    add(0, 0, 1, 1, 32'h10,       32'hFFFFFFDF, 0,1,0,0,0,1, 1,1, 32'h11);
    add(0, 0, 1, 0, 32'h55,       32'hFFFFFFDF, 0,1,0,0,0,1, 2,1, 32'h11);
    add(0, 0, 1, 2, 32'hFFFFFFFF, 32'hFFFFFFDF, 0,0,1,1,1,0, 0,2, 32'hFFFFFFDF);
    add(0, 0, 1, 3, 32'h77,       32'hFFFFFFDF, 0,0,1,1,1,0, 0,2, 32'hFFFFFFDF);
    add(0, 1, 0, 0, 32'h0,        32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    for (int i = 0; i < 5; i++)
      add(0, 0, 0, 0, 32'h0,      32'hFFFFFFDF, 1,0,0,0,0,1, 0,0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        32'hFFFFFFDF, 0,1,0,0,0,1, 0,0, 32'h0);
    add(0, 0, 1, 0, 32'h99,       32'hFFFFFFDF, 0,1,0,0,0,1, 1,0, 32'h0);
    for (int i = 2; i <= 7; i++)
      add(0, 0, 0, 0, 32'h0,      32'hFFFFFFDF, 0,1,0,0,0,1, 16'(i),0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        32'hFFFFFFDF, 0,0,1,0,0,1, 7,0, 32'h0);
    add(0, 0, 0, 0, 32'h0,        32'hFFFFFFDF, 0,0,1,0,0,1, 7,0, 32'h0);

    for (int i = 0; i < tbl.size(); i++) begin
      exp_sig = tbl[i].esig;
      step(tbl[i].rst, tbl[i].start, tbl[i].we, tbl[i].addr, tbl[i].data);
      chk($sformatf("v%0d_cpu_rst", i), {31'b0, cpu_rst}, {31'b0, tbl[i].cr});
      chk($sformatf("v%0d_running", i), {31'b0, running}, {31'b0, tbl[i].run});
      chk($sformatf("v%0d_done", i),    {31'b0, done},    {31'b0, tbl[i].dn});
      chk($sformatf("v%0d_pass", i),    {31'b0, pass},
          {31'b0, SIG_EN ? tbl[i].pe : tbl[i].pd});
      if (tbl[i].cc) chk($sformatf("v%0d_cycles", i), {16'b0, cycles}, {16'b0, tbl[i].cyc});
      chk($sformatf("v%0d_retired", i), {16'b0, retired}, {16'b0, tbl[i].ret});
      chk($sformatf("v%0d_sig", i),     sig, xsig(tbl[i].sg));
    end

    // Halt on the last timeout cycle with a matching signature: halt wins.
    exp_sig = 32'hFFFFFFFD;
    run_up("hto");
    for (int i = 0; i < 7; i++) step(0, 0, 0, 0, 0);
    chk("hto_cycles7", {16'b0, cycles}, 32'd7);
    chk("hto_still_running", {31'b0, running}, 32'd1);
    step(0, 0, 1, 2, 32'hFFFFFFFF);
    chk("hto_done", {31'b0, done}, 32'd1);
    chk("hto_pass", {31'b0, pass}, 32'd1);
    chk("hto_retired", {16'b0, retired}, 32'd1);
    chk("hto_sig", sig, xsig(32'hFFFFFFFD));

    // Same halt program as the table but expected signature 0.
    exp_sig = 32'h0;
    run_up("bad");
    step(0, 0, 1, 1, 32'h10);
    step(0, 0, 1, 2, 32'hFFFFFFFF);
    chk("bad_done", {31'b0, done}, 32'd1);
    chk("bad_pass", {31'b0, pass}, SIG_EN ? 32'd0 : 32'd1);
    chk("bad_sig", sig, xsig(32'hFFFFFFDF));

    // Reset mid-run, with start also high, aborts to IDLE with everything clear.
    run_up("abt");
    step(0, 0, 1, 1, 32'h10);
    chk("abt_retired1", {16'b0, retired}, 32'd1);
    step(1, 1, 1, 2, 32'hFFFFFFFF);
    chk("abt_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("abt_running", {31'b0, running}, 32'd0);
    chk("abt_done", {31'b0, done}, 32'd0);
    chk("abt_pass", {31'b0, pass}, 32'd0);
    chk("abt_cycles", {16'b0, cycles}, 32'd0);
    chk("abt_retired", {16'b0, retired}, 32'd0);
    chk("abt_sig", sig, 32'h0);
    step(0, 0, 0, 0, 0);
    chk("abt_idle_cpu_rst", {31'b0, cpu_rst}, 32'd1);
    chk("abt_idle_running", {31'b0, running}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
